// File: rtl/ser_comm_pkg.sv
// ser_comm_pkg: shared types and default flag constants for the serial-communication datapath.
package ser_comm_pkg;
  typedef enum logic {HUNT, FRAME} state_e;
  localparam int             SER_FLAG_W     = 8;
  localparam logic [7:0]     SER_START_FLAG = 8'b0111_1110;
  localparam logic [7:0]     SER_STOP_FLAG  = 8'b1000_0001;
endpackage

// File: rtl/ser_flag_matcher.sv
// ser_flag_matcher: compares a FLAG_W-bit window against a fixed flag pattern.
module ser_flag_matcher
  import ser_comm_pkg::*;
#(
  parameter int                FLAG_W  = SER_FLAG_W,
  parameter logic [FLAG_W-1:0] PATTERN = SER_START_FLAG
) (
  input  logic [FLAG_W-1:0] win_i,
  output logic              match_o
);
  assign match_o = win_i == PATTERN;
endmodule

// File: rtl/ser_frame_receiver.sv
// ser_frame_receiver: hunts a serial stream for a start flag, forwards payload bits delayed by
// one flag length, closes the frame on a stop flag and aborts it once it exceeds MAX_LEN bits.
module ser_frame_receiver
  import ser_comm_pkg::*;
#(
  parameter int                FLAG_W     = SER_FLAG_W,
  parameter logic [FLAG_W-1:0] START_FLAG = SER_START_FLAG,
  parameter logic [FLAG_W-1:0] STOP_FLAG  = SER_STOP_FLAG,
  parameter int                MAX_LEN    = 64,
  parameter int                LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RcIn,
  output logic             txOut,
  output logic             txValid,
  output logic             txEnd,
  output logic             txAbort,
  output logic [LEN_W-1:0] frameLen,
  output logic             busy
);
  localparam int               CNT_W    = $clog2(FLAG_W + 2);
  localparam logic [CNT_W-1:0] CNT_STOP = CNT_W'(FLAG_W - 1);
  localparam logic [CNT_W-1:0] CNT_EMIT = CNT_W'(FLAG_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FLAG_W + 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  state_e             state_q, state_d;
  logic [FLAG_W-1:0]  sr_q, sr_d, win;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d, len_nx;
  logic [LEN_W-1:0]   frame_len_q, frame_len_d;
  logic               tx_out_q, tx_out_d, tx_valid_q, tx_valid_d;
  logic               tx_end_q, tx_end_d, tx_abort_q, tx_abort_d, busy_q, busy_d;
  logic               start_hit, stop_hit, in_frame, emit, stop, abort, emit_ok, fin;
  assign win  = {sr_q[FLAG_W-2:0], RcIn};
  assign sr_d = win;
  ser_flag_matcher #(.FLAG_W(FLAG_W), .PATTERN(START_FLAG)) u_start (
    .win_i   (win),
    .match_o (start_hit)
  );
  ser_flag_matcher #(.FLAG_W(FLAG_W), .PATTERN(STOP_FLAG)) u_stop (
    .win_i   (win),
    .match_o (stop_hit)
  );
  // cnt counts edges since the start flag; a bit only leaves the window as payload once
  // the window is entirely post-start, and a stop needs the same condition one edge earlier.
  assign in_frame = state_q == FRAME;
  assign emit     = in_frame && cnt_q >= CNT_EMIT;
  assign stop     = in_frame && cnt_q >= CNT_STOP && stop_hit;
  assign abort    = emit && len_q == LEN_MAX;
  assign emit_ok  = emit && !abort;
  assign fin      = stop && !abort;
  assign len_nx   = emit_ok ? len_q + 1'b1 : len_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q     <= HUNT;
      sr_q        <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      tx_out_q    <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_end_q    <= 1'b0;
      tx_abort_q  <= 1'b0;
      frame_len_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      tx_out_q    <= tx_out_d;
      tx_valid_q  <= tx_valid_d;
      tx_end_q    <= tx_end_d;
      tx_abort_q  <= tx_abort_d;
      frame_len_q <= frame_len_d;
      busy_q      <= busy_d;
    end
  always_comb begin
    state_d = in_frame ? ((abort || fin) ? HUNT : FRAME) : (start_hit ? FRAME : HUNT);
    cnt_d   = !in_frame ? '0 : (cnt_q == CNT_SAT ? cnt_q : cnt_q + 1'b1);
    len_d   = !in_frame ? '0 : len_nx;
  end
  always_comb begin
    tx_out_d    = emit_ok & sr_q[FLAG_W-1];
    tx_valid_d  = emit_ok;
    tx_end_d    = fin;
    tx_abort_d  = abort;
    frame_len_d = fin ? len_nx : frame_len_q;
    busy_d      = state_d == FRAME;
  end
  assign txOut    = tx_out_q;
  assign txValid  = tx_valid_q;
  assign txEnd    = tx_end_q;
  assign txAbort  = tx_abort_q;
  assign frameLen = frame_len_q;
  assign busy     = busy_q;
endmodule
